// File: rtl/uart_imem_loader_pkg.sv
// Shared types and image-format constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

    // Loader sequencing: wait for a request, read the length header, stream words, pulse done.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } loader_state_t;

    // Little-endian image layout: a 4-byte word count followed by 4-byte words.
    localparam int unsigned HEADER_BYTES   = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Little-endian assembly: each new byte enters at the top, so after four
    // bytes the first byte received sits in bits [7:0].
    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc,
                                                  input logic [7:0]  new_byte);
        return {new_byte, acc[31:8]};
    endfunction

endpackage

// File: rtl/uart_imem_loader_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level input, followed by a
// single-cycle rising-edge pulse. Reusable for any button or board pin.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state: shift the input through the synchronizer and remember the last level.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // A held-high level produces exactly one pulse.
    assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: turns a UART byte stream (length header + little-endian words)
// into sequential single-cycle instruction-memory writes starting at word 0,
// holding the CPU while loading and pulsing load_done when the image is in.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS     = 1024,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    // Idle counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       HDR_LAST_IDX = 2'(HEADER_BYTES - 1);
    localparam logic [1:0]       WRD_LAST_IDX = 2'(BYTES_PER_WORD - 1);
    localparam logic [31:0]      MAX_WORDS    = 32'(IMEM_WORDS);

    logic flash_start;

    sync_edge_detect u_flash_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (flash),
        .rise_pulse (flash_start)
    );

    loader_state_t     state_q,    state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shift_q,    shift_d;
    logic [ADDR_W:0]   len_q,      len_d;
    logic [ADDR_W:0]   words_q,    words_d;
    logic [TMO_W-1:0]  tmo_q,      tmo_d;
    logic              we_q,       we_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              err_q,      err_d;

    logic [31:0]       assembled;
    logic              timed_out;
    logic              last_write;

    // Next-state and datapath: header parse, word assembly, write issue, timeout.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        len_d      = len_q;
        words_d    = words_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        err_d      = err_q;
        assembled  = shift_in_byte(shift_q, byte_data);
        timed_out  = 1'b0;
        last_write = we_q && ((words_q + 1'b1) == len_q);

        // Idle-cycle counting while a load is in progress; any byte resets it.
        if ((state_q == ST_LEN) || (state_q == ST_DATA)) begin
            if (byte_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                timed_out = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Stray bytes here (including trailing bytes of an image) are dropped.
            end

            ST_LEN: begin
                if (byte_valid) begin
                    shift_d    = assembled;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == HDR_LAST_IDX) begin
                        if (assembled == 32'd0) begin
                            state_d = ST_DONE;
                        end else if (assembled > MAX_WORDS) begin
                            // Rejecting oversize images keeps the write address in range.
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                            len_d   = assembled[ADDR_W:0];
                        end
                    end
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                end
            end

            ST_DATA: begin
                // The write strobe issued last cycle lands now; count it.
                if (we_q) begin
                    words_d = words_q + 1'b1;
                end
                // Bytes keep flowing during the write cycle, so the finished
                // word is held in its own register apart from the shifter.
                if (byte_valid) begin
                    shift_d    = assembled;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == WRD_LAST_IDX) begin
                        we_d    = 1'b1;
                        wdata_d = assembled;
                    end
                end
                // A completed image wins over a coincident timeout.
                if (last_write) begin
                    state_d    = ST_DONE;
                    we_d       = 1'b0;
                    byte_idx_d = '0;
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request restarts from scratch and discards any byte this cycle.
        if (flash_start) begin
            state_d    = ST_LEN;
            byte_idx_d = '0;
            shift_d    = '0;
            len_d      = '0;
            words_d    = '0;
            tmo_d      = '0;
            we_d       = 1'b0;
            err_d      = 1'b0;
        end
    end

    // Loader state registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            words_q    <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            words_q    <= words_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    // Write address is the running word count, so words land at 0, 1, 2, ...
    assign imem_we      = we_q;
    assign imem_addr    = words_q[ADDR_W-1:0];
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = (state_q != ST_IDLE);
    assign load_done    = (state_q == ST_DONE);
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;

    localparam int IMEM_WORDS     = 1024;
    localparam int ADDR_W         = 10;
    localparam int TIMEOUT_CYCLES = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              flash;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    uart_imem_loader #(
        .IMEM_WORDS     (IMEM_WORDS),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flash        (flash),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          last_we_cyc = 0;
    int          done_cnt = 0;
    wr_t         wq[$];
    int unsigned img_words[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe memory writes and done pulses away from the active edge.
    always @(negedge clk) begin
        wr_t w;
        if (imem_we === 1'b1) begin
            w.addr = imem_addr;
            w.data = imem_wdata;
            wq.push_back(w);
            last_we_cyc = cyc;
        end
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic make_random_image(input int n);
        img_words.delete();
        for (int i = 0; i < n; i++) img_words.push_back($urandom);
    endtask

    // Reference image stream: 4-byte LE count, then each word as 4 LE bytes.
    task automatic build_tx();
        int unsigned n;
        tx_q.delete();
        n = img_words.size();
        for (int b = 0; b < 4; b++) tx_q.push_back(8'((n >> (8 * b)) & 32'hFF));
        foreach (img_words[i])
            for (int b = 0; b < 4; b++) tx_q.push_back(8'((img_words[i] >> (8 * b)) & 32'hFF));
    endtask

    task automatic send_bytes(input int max_gap);
        foreach (tx_q[i]) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0) begin
                byte_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_data  = tx_q[i];
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    // Pulse flash and confirm the loader entered a clean load.
    task automatic start_load();
        @(negedge clk);
        flash = 1'b1;
        repeat (2) @(negedge clk);
        flash = 1'b0;
        @(negedge clk);
        chk("start_hold", cpu_hold, 1);
        chk("start_words", words_loaded, 0);
        chk("start_err", load_error, 0);
    endtask

    // Send the current image and check writes, done timing and counters.
    task automatic run_image(input int max_gap);
        int n;
        n = img_words.size();
        build_tx();
        wq.delete();
        done_cnt = 0;
        send_bytes(max_gap);
        for (int i = 0; i < 40; i++) begin
            if (load_done === 1'b1) break;
            @(negedge clk);
        end
        chk("done_seen", load_done, 1);
        chk("hold_at_done", cpu_hold, 1);
        if (n > 0) chk("done_after_write", cyc - last_we_cyc, 1);
        chk("words_at_done", words_loaded, n);
        @(negedge clk);
        chk("hold_after_done", cpu_hold, 0);
        chk("done_one_cycle", load_done, 0);
        chk("err_after_load", load_error, 0);
        chk("done_count", done_cnt, 1);
        chk("wr_count", wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), wq[i].addr, i);
            chk($sformatf("wr_data[%0d]", i), wq[i].data, img_words[i]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_err"}, load_error, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flash = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal two-word image, bytes back-to-back.
        img_words.delete();
        img_words.push_back(32'h00100513);
        img_words.push_back(32'h00200593);
        start_load();
        run_image(0);

        // Random images with random inter-byte gaps.
        for (int r = 0; r < 3; r++) begin
            make_random_image(int'($urandom_range(8, 1)));
            start_load();
            run_image(r == 0 ? 0 : 5);
        end

        // Zero-length image.
        img_words.delete();
        start_load();
        run_image(3);

        // Oversize header N = IMEM_WORDS + 1.
        start_load();
        tx_q.delete();
        tx_q.push_back(8'h01); tx_q.push_back(8'h04); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        wq.delete(); done_cnt = 0;
        send_bytes(2);
        repeat (10) @(negedge clk);
        chk("oversize_err", load_error, 1);
        chk("oversize_hold", cpu_hold, 0);
        chk("oversize_words", words_loaded, 0);
        // Bytes while idle are ignored.
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
        send_bytes(0);
        repeat (3) @(negedge clk);
        chk("oversize_idle_hold", cpu_hold, 0);
        chk("oversize_writes", wq.size(), 0);
        chk("oversize_dones", done_cnt, 0);

        // Timeout: N=3, header + 5 data bytes, then silence.
        make_random_image(3);
        start_load();
        build_tx();
        tx_q = tx_q[0:8];
        wq.delete(); done_cnt = 0;
        send_bytes(0);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        chk("tmo_before_err", load_error, 0);
        chk("tmo_before_hold", cpu_hold, 1);
        @(negedge clk);
        chk("tmo_err", load_error, 1);
        chk("tmo_hold", cpu_hold, 0);
        chk("tmo_words", words_loaded, 1);
        repeat (5) @(negedge clk);
        chk("tmo_writes", wq.size(), 1);
        if (wq.size() > 0) chk("tmo_word0", wq[0].data, img_words[0]);
        chk("tmo_dones", done_cnt, 0);

        // Restart after 2 of 4 words, then a fresh image from address 0.
        make_random_image(4);
        start_load();
        build_tx();
        tx_q = tx_q[0:11];
        wq.delete();
        send_bytes(1);
        @(negedge clk);
        chk("restart_pre_words", words_loaded, 2);
        chk("restart_pre_writes", wq.size(), 2);
        start_load();
        make_random_image(3);
        run_image(2);

        // Flash held high across done: no second load.
        make_random_image(1);
        @(negedge clk);
        flash = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_hold", cpu_hold, 1);
        run_image(1);
        repeat (10) @(negedge clk);
        chk("held_no_retrigger", cpu_hold, 0);
        chk("held_done_count", done_cnt, 1);
        flash = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of DATA, then a clean load.
        make_random_image(2);
        start_load();
        build_tx();
        tx_q = tx_q[0:9];
        send_bytes(0);
        chk("mid_words", words_loaded, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        make_random_image(5);
        start_load();
        run_image(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
